// File: rtl/accumulator4_sequencer_if.sv
// accumulator4_sequencer_if: bundles the instruction-fetch port and the
// accumulator4 datapath port driven by the micro-sequencer.
// master = sequencer side, slave = instruction store / accumulator side.
interface accumulator4_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic [15:0]       fetch_data;

    logic              acc_enable;
    logic [4:0]        acc_opcode;
    logic [3:0]        acc_operand_hi;
    logic [3:0]        acc_operand_lo;
    logic              acc_carry;
    logic [7:0]        acc_value;
    logic              acc_carry_out;

    modport master (
        output fetch_valid, fetch_addr,
        input  fetch_ready, fetch_data,
        output acc_enable, acc_opcode, acc_operand_hi, acc_operand_lo, acc_carry,
        input  acc_value, acc_carry_out
    );

    modport slave (
        input  fetch_valid, fetch_addr,
        output fetch_ready, fetch_data,
        input  acc_enable, acc_opcode, acc_operand_hi, acc_operand_lo, acc_carry,
        output acc_value, acc_carry_out
    );
endinterface

// File: rtl/accumulator4_sequencer.sv
// accumulator4_sequencer: fetches 16-bit instructions, drives one accumulator4
// instance and evaluates conditional branches on its result.
// Optional instruction-count watchdog enabled by defining ACC4SEQ_WATCHDOG_EN.
module accumulator4_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        start_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    accumulator4_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    localparam logic [4:0] OP_ADDC = 5'b10001;

    state_e            r_state, w_nextState;
    logic [ADDR_W-1:0] r_pc, w_nextPc, w_pcInc;
    logic              r_carry, w_nextCarry;
    logic [15:0]       r_ir, w_nextIr;
    logic              r_busy, w_nextBusy;
    logic              r_done, w_nextDone;
    logic [4:0]        r_accOpcode, w_nextAccOpcode;
    logic [3:0]        r_accHi, w_nextAccHi;
    logic [3:0]        r_accLo, w_nextAccLo;
    logic              w_fetchValid, w_accEnable, w_branchTaken;

`ifdef ACC4SEQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
    logic [WDOG_W-1:0] r_wdogCount, w_nextWdogCount;
    logic              r_wdogPend, w_nextWdogPend;
    logic              r_error, w_nextError;
    logic              w_wdogHit;
`endif

    // State register of the sequencer FSM
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    // Next-state, register updates and strobes; an ACC instruction parks its
    // fields in the hold registers at EXEC so they stay on the bus afterwards,
    // and a watchdog hit on an ACC is deferred to SETTLE so the carry update
    // of that instruction still completes
    always_comb begin
        w_nextState     = r_state;
        w_nextPc        = r_pc;
        w_nextCarry     = r_carry;
        w_nextIr        = r_ir;
        w_nextBusy      = r_busy;
        w_nextDone      = 1'b0;
        w_nextAccOpcode = r_accOpcode;
        w_nextAccHi     = r_accHi;
        w_nextAccLo     = r_accLo;
        w_fetchValid    = 1'b0;
        w_accEnable     = 1'b0;
        w_branchTaken   = 1'b0;
        w_pcInc         = r_pc + ADDR_W'(1);
`ifdef ACC4SEQ_WATCHDOG_EN
        w_nextWdogCount = r_wdogCount;
        w_nextWdogPend  = r_wdogPend;
        w_nextError     = r_error;
        w_wdogHit       = (r_wdogCount == WDOG_W'(WDOG_LIMIT - 1));
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nextPc    = start_addr;
                    w_nextBusy  = 1'b1;
                    w_nextState = ST_FETCH;
`ifdef ACC4SEQ_WATCHDOG_EN
                    w_nextWdogCount = '0;
                    w_nextWdogPend  = 1'b0;
                    w_nextError     = 1'b0;
`endif
                end
            end
            ST_FETCH: begin
                w_fetchValid = 1'b1;
                if (bus.fetch_ready) begin
                    w_nextIr    = bus.fetch_data;
                    w_nextState = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (r_ir[15:14])
                    2'b00: begin
                        w_accEnable     = 1'b1;
                        w_nextAccOpcode = r_ir[12:8];
                        w_nextAccHi     = r_ir[7:4];
                        w_nextAccLo     = r_ir[3:0];
                        w_nextState     = ST_SETTLE;
                    end
                    2'b01: begin
                        case (r_ir[13:12])
                            2'b00:   w_branchTaken = 1'b1;
                            2'b01:   w_branchTaken = (bus.acc_value == 8'd0);
                            2'b10:   w_branchTaken = bus.acc_value[7];
                            default: w_branchTaken = r_carry;
                        endcase
                        w_nextPc    = w_branchTaken ? r_ir[ADDR_W-1:0] : w_pcInc;
                        w_nextState = ST_FETCH;
                    end
                    2'b10: begin
                        w_nextCarry = r_ir[0];
                        w_nextPc    = w_pcInc;
                        w_nextState = ST_FETCH;
                    end
                    default: begin
                        w_nextDone  = 1'b1;
                        w_nextBusy  = 1'b0;
                        w_nextState = ST_IDLE;
                    end
                endcase
`ifdef ACC4SEQ_WATCHDOG_EN
                w_nextWdogCount = r_wdogCount + WDOG_W'(1);
                if (w_wdogHit) begin
                    if (r_ir[15:14] == 2'b00) begin
                        w_nextWdogPend = 1'b1;
                    end else begin
                        w_nextError = 1'b1;
                        w_nextDone  = 1'b1;
                        w_nextBusy  = 1'b0;
                        w_nextState = ST_IDLE;
                    end
                end
`endif
            end
            ST_SETTLE: begin
                if (r_accOpcode == OP_ADDC) w_nextCarry = bus.acc_carry_out;
                w_nextPc    = w_pcInc;
                w_nextState = ST_FETCH;
`ifdef ACC4SEQ_WATCHDOG_EN
                if (r_wdogPend) begin
                    w_nextWdogPend = 1'b0;
                    w_nextError    = 1'b1;
                    w_nextDone     = 1'b1;
                    w_nextBusy     = 1'b0;
                    w_nextState    = ST_IDLE;
                end
`endif
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Datapath registers: PC, carry flag, instruction register, status flags
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_pc        <= '0;
            r_carry     <= 1'b0;
            r_ir        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_accOpcode <= '0;
            r_accHi     <= '0;
            r_accLo     <= '0;
`ifdef ACC4SEQ_WATCHDOG_EN
            r_wdogCount <= '0;
            r_wdogPend  <= 1'b0;
            r_error     <= 1'b0;
`endif
        end else begin
            r_pc        <= w_nextPc;
            r_carry     <= w_nextCarry;
            r_ir        <= w_nextIr;
            r_busy      <= w_nextBusy;
            r_done      <= w_nextDone;
            r_accOpcode <= w_nextAccOpcode;
            r_accHi     <= w_nextAccHi;
            r_accLo     <= w_nextAccLo;
`ifdef ACC4SEQ_WATCHDOG_EN
            r_wdogCount <= w_nextWdogCount;
            r_wdogPend  <= w_nextWdogPend;
            r_error     <= w_nextError;
`endif
        end
    end

    assign bus.fetch_valid    = w_fetchValid;
    assign bus.fetch_addr     = r_pc;
    assign bus.acc_enable     = w_accEnable;
    assign bus.acc_opcode     = w_accEnable ? r_ir[12:8] : r_accOpcode;
    assign bus.acc_operand_hi = w_accEnable ? r_ir[7:4]  : r_accHi;
    assign bus.acc_operand_lo = w_accEnable ? r_ir[3:0]  : r_accLo;
    assign bus.acc_carry      = r_carry;
    assign busy               = r_busy;
    assign done               = r_done;

`ifdef ACC4SEQ_WATCHDOG_EN
    assign error = r_error;
`else
    logic w_unusedWdogLimit;
    assign w_unusedWdogLimit = (WDOG_LIMIT > 0);
    assign error             = 1'b0;
`endif
endmodule

// File: tb/tb_accumulator4_sequencer.sv
// tb_accumulator4_sequencer: scoreboard bench for accumulator4_sequencer.
// Expected fetch addresses and accumulator pulses are queued when a program
// is launched and popped when the DUT performs them.
module tb_accumulator4_sequencer;
    localparam int ADDR_W = 8;
    localparam int WDOG   = 16;

    logic        aclk = 1'b0;
    logic        areset;
    logic        start;
    logic [7:0]  startAddr;
    logic        busy, done, error;
    logic        readyEn;
    logic [7:0]  accValue;
    logic        accCarryOut;
    logic [15:0] rom [256];

    int checks    = 0;
    int failures  = 0;
    int doneCount = 0;

    logic [7:0]  expFetch [$];
    logic [13:0] expAcc   [$];

    accumulator4_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    assign bus.fetch_ready   = readyEn;
    assign bus.fetch_data    = rom[bus.fetch_addr];
    assign bus.acc_value     = accValue;
    assign bus.acc_carry_out = accCarryOut;

    accumulator4_sequencer #(.ADDR_W(ADDR_W), .WDOG_LIMIT(WDOG)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .start      (start),
        .start_addr (startAddr),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .bus        (bus)
    );

    // Free-running 10 ns clock
    always #5 aclk = ~aclk;

    // Counts one comparison and reports it if the values differ
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic pushFetch(input logic [7:0] a);
        expFetch.push_back(a);
    endtask

    task automatic pushAcc(input logic [4:0] op, input logic [3:0] hi, input logic [3:0] lo, input logic c);
        expAcc.push_back({op, hi, lo, c});
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT fetches or pulses
    always @(negedge aclk) begin
        if (!areset) begin
            if (bus.fetch_valid && bus.fetch_ready) begin
                if (expFetch.size() > 0)
                    checkOutput("fetch_addr", 32'(bus.fetch_addr), 32'(expFetch.pop_front()));
                else
                    checkOutput("fetch_unexpected", 32'(bus.fetch_addr), 32'hFFFF_FFFF);
            end
            if (bus.acc_enable) begin
                if (expAcc.size() > 0)
                    checkOutput("acc_pulse", 32'({bus.acc_opcode, bus.acc_operand_hi, bus.acc_operand_lo, bus.acc_carry}),
                                32'(expAcc.pop_front()));
                else
                    checkOutput("acc_unexpected", 32'({bus.acc_opcode, bus.acc_operand_hi, bus.acc_operand_lo}), 32'hFFFF_FFFF);
            end
            if (done) doneCount++;
        end
    end

    // Waits (bounded) for the done pulse, n is the cycle index already reached
    task automatic waitDone(input int nStart, input int expCycles, input bit holdStart);
        int n;
        n = nStart;
        while (done !== 1'b1 && n < 400) begin
            start = holdStart && (n < 4);
            @(posedge aclk); #1;
            n++;
        end
        start = 1'b0;
        checkOutput("done_seen", 32'(done), 32'd1);
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        if (expCycles > 0) checkOutput("cycles", 32'(n + 1), 32'(expCycles));
        @(posedge aclk); #1;
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("fetch_q_drained", 32'(expFetch.size()), 32'd0);
        checkOutput("acc_q_drained", 32'(expAcc.size()), 32'd0);
    endtask

    // Launches a program at addr and runs it to completion
    task automatic applyStimulus(input logic [7:0] addr, input int expCycles, input bit holdStart);
        start     = 1'b1;
        startAddr = addr;
        @(posedge aclk); #1;
        start = 1'b0;
        if (holdStart) startAddr = 8'h55;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("error_after_start", 32'(error), 32'd0);
        waitDone(1, expCycles, holdStart);
    endtask

    initial begin
        int d0;
        areset      = 1'b1;
        start       = 1'b0;
        startAddr   = 8'h00;
        readyEn     = 1'b1;
        accValue    = 8'h00;
        accCarryOut = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
        rom[8'h00] = 16'h033C;
        rom[8'h01] = 16'hC000;
        rom[8'h20] = 16'h8001;
        rom[8'h21] = 16'h1112;
        rom[8'h22] = 16'h1234;
        rom[8'h23] = 16'h8001;
        rom[8'h24] = 16'h1256;
        rom[8'h25] = 16'h1278;
        rom[8'h26] = 16'hC000;
        rom[8'h04] = 16'h5010;
        rom[8'h06] = 16'h6010;
        rom[8'h08] = 16'h7010;
        rom[8'h09] = 16'h4010;
        rom[8'h40] = 16'h0567;
        rom[8'hFF] = 16'h8000;

        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        checkOutput("rst_fetch_addr", 32'(bus.fetch_addr), 32'd0);
        checkOutput("rst_acc_enable", 32'(bus.acc_enable), 32'd0);
        checkOutput("rst_acc_bus", 32'({bus.acc_opcode, bus.acc_operand_hi, bus.acc_operand_lo, bus.acc_carry}), 32'd0);
        areset = 1'b0;
        @(posedge aclk); #1;

        $display("[TB] basic ACC + HALT");
        pushFetch(8'h00); pushFetch(8'h01);
        pushAcc(5'b00011, 4'h3, 4'hC, 1'b0);
        applyStimulus(8'h00, 7, 1'b0);
        checkOutput("acc_hold_opcode", 32'(bus.acc_opcode), 32'(5'b00011));

        $display("[TB] carry chain, start ignored while busy");
        for (int a = 8'h20; a <= 8'h26; a++) pushFetch(8'(a));
        pushAcc(5'b10001, 4'h1, 4'h2, 1'b1);
        pushAcc(5'b10010, 4'h3, 4'h4, 1'b0);
        pushAcc(5'b10010, 4'h5, 4'h6, 1'b1);
        pushAcc(5'b10010, 4'h7, 4'h8, 1'b1);
        applyStimulus(8'h20, -1, 1'b1);
        checkOutput("carry_final", 32'(bus.acc_carry), 32'd1);

        $display("[TB] branches");
        accValue = 8'h00; pushFetch(8'h04); pushFetch(8'h10);
        applyStimulus(8'h04, 6, 1'b0);
        accValue = 8'h01; pushFetch(8'h04); pushFetch(8'h05);
        applyStimulus(8'h04, 6, 1'b0);
        accValue = 8'h80; pushFetch(8'h06); pushFetch(8'h10);
        applyStimulus(8'h06, -1, 1'b0);
        accValue = 8'h7F; pushFetch(8'h06); pushFetch(8'h07);
        applyStimulus(8'h06, -1, 1'b0);
        pushFetch(8'h08); pushFetch(8'h10);
        applyStimulus(8'h08, -1, 1'b0);
        pushFetch(8'h09); pushFetch(8'h10);
        applyStimulus(8'h09, -1, 1'b0);

        $display("[TB] PC wrap");
        pushFetch(8'hFF); pushFetch(8'h00); pushFetch(8'h01);
        pushAcc(5'b00011, 4'h3, 4'hC, 1'b0);
        applyStimulus(8'hFF, -1, 1'b0);
        checkOutput("carry_after_wrap", 32'(bus.acc_carry), 32'd0);

        $display("[TB] fetch stall");
        readyEn   = 1'b0;
        start     = 1'b1;
        startAddr = 8'h10;
        @(posedge aclk); #1;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_valid", 32'(bus.fetch_valid), 32'd1);
            checkOutput("stall_addr", 32'(bus.fetch_addr), 32'h10);
            @(posedge aclk); #1;
        end
        pushFetch(8'h10);
        readyEn = 1'b1;
        waitDone(6, -1, 1'b0);

        $display("[TB] reset during EXEC");
        d0 = doneCount;
        pushFetch(8'h40);
        start     = 1'b1;
        startAddr = 8'h40;
        @(posedge aclk); #1;
        start = 1'b0;
        @(posedge aclk); #1;
        checkOutput("exec_acc_enable", 32'(bus.acc_enable), 32'd1);
        areset = 1'b1;
        #1;
        checkOutput("rst_exec_acc_enable", 32'(bus.acc_enable), 32'd0);
        checkOutput("rst_exec_busy", 32'(busy), 32'd0);
        checkOutput("rst_exec_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_exec_no_done", 32'(doneCount), 32'(d0));
        checkOutput("rst_exec_pc", 32'(bus.fetch_addr), 32'd0);
        checkOutput("rst_exec_q", 32'(expFetch.size()), 32'd0);
        areset = 1'b0;
        @(posedge aclk); #1;

        rom[8'h00] = 16'h4000;
`ifdef ACC4SEQ_WATCHDOG_EN
        $display("[TB] watchdog abort");
        for (int k = 0; k < WDOG; k++) pushFetch(8'h00);
        applyStimulus(8'h00, 2 * WDOG + 2, 1'b0);
        checkOutput("wdog_error", 32'(error), 32'd1);
        pushFetch(8'h10);
        applyStimulus(8'h10, -1, 1'b0);
        checkOutput("wdog_error_cleared", 32'(error), 32'd0);
`else
        $display("[TB] endless loop without watchdog");
        for (int k = 0; k < 20; k++) pushFetch(8'h00);
        start     = 1'b1;
        startAddr = 8'h00;
        @(posedge aclk); #1;
        start = 1'b0;
        repeat (39) @(posedge aclk);
        #1;
        checkOutput("loop_error", 32'(error), 32'd0);
        checkOutput("loop_busy", 32'(busy), 32'd1);
        checkOutput("loop_fetches", 32'(expFetch.size()), 32'd0);
        areset = 1'b1;
        @(posedge aclk); #1;
        expFetch.delete();
        areset = 1'b0;
        @(posedge aclk); #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
